controle_principal_mc: RTL and testbench

- Multicycle main control FSM for the 8-bit processor.
- Captures the 4-bit opcode from the memory data bus at fetch.
- Sequences fetch/decode/execute/memory/writeback and handshakes with variable-latency memory via mem_ready.
- Drives opAlu (the 3-bit ALU-control code consumed by the ALU control decoder) plus all datapath enables.

---
 rtl/controle_principal_mc.sv | 210 +++++++++++++++++++++
 tb/tb_controle_principal_mc.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_principal_mc.sv
// Multicycle main control FSM for the 8-bit processor. It sequences fetch, decode,
// execute, memory and writeback, and guards every memory handshake with a watchdog.
module controle_principal_mc #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [2:0] opAlu,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       fault
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_MF   = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0110;
    localparam logic [3:0] OP_SW   = 4'b0111;
    localparam logic [3:0] OP_BEQ  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_MF  = 3'b110;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_MEM,
        S_WB_ALU,
        S_BRANCH,
        S_JUMP,
        S_HALT,
        S_FAULT
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_mem_wait;
    logic             wait_timeout;

    // Only the opcode nibble of the fetched byte matters to control.
    logic unused_mem_data;
    assign unused_mem_data = ^mem_data[3:0];

    assign in_mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign wait_timeout = in_mem_wait && !mem_ready && (cnt_q == WAIT_LIM);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = '0;

        if (in_mem_wait && !mem_ready && !wait_timeout) begin
            cnt_d = cnt_q + 1'b1;
        end

        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    op_d    = mem_data[7:4];
                    state_d = S_DECODE;
                end else if (wait_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                unique case (op_q)
                    OP_AND, OP_OR, OP_ADD,
                    OP_SUB, OP_SLT, OP_MF: state_d = S_EXEC_R;
                    OP_ADDI:               state_d = S_EXEC_I;
                    OP_LW, OP_SW:          state_d = S_MEM_ADDR;
                    OP_BEQ:                state_d = S_BRANCH;
                    OP_JMP:                state_d = S_JUMP;
                    OP_HALT:               state_d = S_HALT;
                    default:               state_d = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR:         state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (wait_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_WB_MEM, S_WB_ALU,
            S_BRANCH, S_JUMP:   state_d = S_FETCH;
            S_HALT:             state_d = S_HALT;
            S_FAULT:            state_d = S_FAULT;
            default:            state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decode is gated by reset_n so an in-flight strobe is cut the moment reset asserts.
    always_comb begin
        opAlu      = ALU_ADD;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        if (reset_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b10;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    opAlu     = (op_q == OP_MF) ? ALU_MF : op_q[2:0];
                end
                S_EXEC_I, S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_WB_ALU: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    opAlu     = ALU_SUB;
                    pc_src    = 2'b01;
                    pc_write  = zero;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_principal_mc.sv
// Bench for controle_principal_mc: directed vector table, hand-written corner sequences,
// then randomized traffic checked against an instruction-level plan model.
module tb_controle_principal_mc;

    localparam int WAIT_MAX = 15;

    typedef struct packed {
        logic [2:0] op_alu;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       mem_to_reg;
        logic       halted;
        logic       fault;
    } out_t;

    typedef struct {
        string      name;
        logic [7:0] md;
        logic       rdy;
        logic       z;
        out_t       exp;
    } vec_t;

    typedef enum {PH_FETCH, PH_DECODE, PH_EXEC_R, PH_EXEC_I, PH_ADDR, PH_RD, PH_WR,
                  PH_WBM, PH_WBA, PH_BR, PH_JMP, PH_HALT, PH_FAULT} ph_e;

    logic       clock, reset_n, mem_ready, zero;
    logic [7:0] mem_data;
    logic [2:0] opAlu;
    logic       pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic       reg_write, mem_to_reg, halted, fault;
    out_t       got;

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs[$];

    ph_e        q[$];
    logic [3:0] m_op;
    int         m_wait;

    controle_principal_mc #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clock(clock), .reset_n(reset_n), .mem_data(mem_data), .mem_ready(mem_ready),
        .zero(zero), .opAlu(opAlu), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .halted(halted), .fault(fault)
    );

    assign got = {opAlu, pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d,
                  alu_src_a, alu_src_b, reg_write, mem_to_reg, halted, fault};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    endtask

    function automatic out_t mk(input logic [2:0] alu, input logic pcw, input logic [1:0] ps,
                                input logic irw, input logic mr, input logic mw, input logic iod,
                                input logic asa, input logic [1:0] asb, input logic rw,
                                input logic m2r, input logic h, input logic f);
        return {alu, pcw, ps, irw, mr, mw, iod, asa, asb, rw, m2r, h, f};
    endfunction

    // Spec-level expectations: what each phase of an instruction drives.
    function automatic out_t model_out(input ph_e ph, input logic [3:0] op, input logic rdy,
                                       input logic z);
        out_t o;
        o = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        case (ph)
            PH_FETCH:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            PH_DECODE: o.alu_src_b = 2'b10;
            PH_EXEC_R: begin
                o.alu_src_a = 1;
                case (op)
                    4'h0: o.op_alu = 3'b000;
                    4'h1: o.op_alu = 3'b001;
                    4'h2: o.op_alu = 3'b010;
                    4'h3: o.op_alu = 3'b011;
                    4'h4: o.op_alu = 3'b100;
                    default: o.op_alu = 3'b110;
                endcase
            end
            PH_EXEC_I, PH_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            PH_RD:  begin o.mem_read = 1;  o.i_or_d = 1; end
            PH_WR:  begin o.mem_write = 1; o.i_or_d = 1; end
            PH_WBM: begin o.reg_write = 1; o.mem_to_reg = 1; end
            PH_WBA: o.reg_write = 1;
            PH_BR:  begin o.alu_src_a = 1; o.op_alu = 3'b011; o.pc_src = 2'b01; o.pc_write = z; end
            PH_JMP: begin o.pc_src = 2'b10; o.pc_write = 1; end
            PH_HALT:  o.halted = 1;
            PH_FAULT: o.fault = 1;
            default: ;
        endcase
        return o;
    endfunction

    function automatic ph_e cur_ph();
        return (q.size() == 0) ? PH_FETCH : q[0];
    endfunction

    task automatic plan_for(input logic [3:0] op);
        q.push_back(PH_DECODE);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin q.push_back(PH_EXEC_R); q.push_back(PH_WBA); end
            4'hA: begin q.push_back(PH_EXEC_I); q.push_back(PH_WBA); end
            4'h6: begin q.push_back(PH_ADDR); q.push_back(PH_RD); q.push_back(PH_WBM); end
            4'h7: begin q.push_back(PH_ADDR); q.push_back(PH_WR); end
            4'h8: q.push_back(PH_BR);
            4'h9: q.push_back(PH_JMP);
            4'hF: q.push_back(PH_HALT);
            default: ;
        endcase
    endtask

    task automatic model_reset();
        q.delete();
        m_op   = 4'h0;
        m_wait = 0;
    endtask

    task automatic model_step(input logic [7:0] md, input logic rdy);
        ph_e ph = cur_ph();
        if (ph == PH_FETCH || ph == PH_RD || ph == PH_WR) begin
            if (rdy) begin
                m_wait = 0;
                if (ph == PH_FETCH) begin
                    m_op = md[7:4];
                    plan_for(md[7:4]);
                end else begin
                    void'(q.pop_front());
                end
            end else if (m_wait == WAIT_MAX) begin
                q.delete();
                q.push_back(PH_FAULT);
                m_wait = 0;
            end else begin
                m_wait++;
            end
        end else if (ph != PH_HALT && ph != PH_FAULT) begin
            void'(q.pop_front());
        end
    endtask

    task automatic drive_cycle(input logic [7:0] md, input logic rdy, input logic z);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        mem_data  = md;
        mem_ready = rdy;
        zero      = z;
        @(negedge clock);
    endtask

    task automatic do_reset(input out_t exp_rst);
        @(posedge clock);
        #1;
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        @(negedge clock);
        check("reset_outputs", got, exp_rst);
        model_reset();
    endtask

    task automatic add(input string n, input logic [7:0] md, input logic rdy, input logic z,
                       input out_t e);
        vec_t v;
        v.name = n; v.md = md; v.rdy = rdy; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic out_t exec_o(input logic [2:0] alu);
        return mk(alu, 0, 2'b00, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
    endfunction

    initial begin
        out_t o_reset, o_fetch_wait, o_fetch_go, o_decode, o_exec_i, o_wb_alu, o_wb_mem;
        out_t o_mem_rd, o_mem_wr, o_br1, o_br0, o_jump, o_halt, o_fault;

        o_reset      = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        o_fetch_wait = mk(3'b010, 0, 2'b00, 0, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
        o_fetch_go   = mk(3'b010, 1, 2'b00, 1, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0);
        o_decode     = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
        o_exec_i     = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0);
        o_wb_alu     = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0);
        o_wb_mem     = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        o_mem_rd     = mk(3'b010, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        o_mem_wr     = mk(3'b010, 0, 2'b00, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
        o_br1        = mk(3'b011, 1, 2'b01, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        o_br0        = mk(3'b011, 0, 2'b01, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        o_jump       = mk(3'b010, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        o_halt       = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        o_fault      = mk(3'b010, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

        add("add_fetch", 8'h23, 1, 0, o_fetch_go);  add("add_decode", 8'h00, 0, 0, o_decode);
        add("add_exec", 8'h00, 0, 0, exec_o(3'b010)); add("add_wb", 8'h00, 0, 0, o_wb_alu);
        add("slt_fetch", 8'h47, 1, 0, o_fetch_go);  add("slt_decode", 8'h00, 0, 0, o_decode);
        add("slt_exec", 8'h00, 0, 0, exec_o(3'b100)); add("slt_wb", 8'h00, 0, 0, o_wb_alu);
        add("sub_fetch", 8'h31, 1, 0, o_fetch_go);  add("sub_decode", 8'h00, 0, 0, o_decode);
        add("sub_exec", 8'h00, 0, 0, exec_o(3'b011)); add("sub_wb", 8'h00, 0, 0, o_wb_alu);
        add("mf_fetch", 8'h5A, 1, 0, o_fetch_go);   add("mf_decode", 8'h00, 0, 0, o_decode);
        add("mf_exec", 8'h00, 0, 0, exec_o(3'b110)); add("mf_wb", 8'h00, 0, 0, o_wb_alu);
        add("and_fetch", 8'h0F, 1, 0, o_fetch_go);  add("and_decode", 8'h00, 0, 0, o_decode);
        add("and_exec", 8'h00, 0, 0, exec_o(3'b000)); add("and_wb", 8'h00, 0, 0, o_wb_alu);
        add("beq1_fetch", 8'h80, 1, 0, o_fetch_go); add("beq1_decode", 8'h00, 0, 1, o_decode);
        add("beq1_branch", 8'h00, 0, 1, o_br1);
        add("beq0_fetch", 8'h8C, 1, 1, o_fetch_go); add("beq0_decode", 8'h00, 0, 0, o_decode);
        add("beq0_branch", 8'h00, 0, 0, o_br0);
        add("lw_fetch", 8'h60, 1, 0, o_fetch_go);   add("lw_decode", 8'h00, 0, 0, o_decode);
        add("lw_addr", 8'h00, 0, 0, o_exec_i);
        add("lw_rd_wait1", 8'h00, 0, 0, o_mem_rd);  add("lw_rd_wait2", 8'h00, 0, 0, o_mem_rd);
        add("lw_rd_wait3", 8'h00, 0, 0, o_mem_rd);  add("lw_rd_done", 8'h55, 1, 0, o_mem_rd);
        add("lw_wb", 8'h00, 0, 0, o_wb_mem);
        add("sw_fetch", 8'h7E, 1, 0, o_fetch_go);   add("sw_decode", 8'h00, 0, 0, o_decode);
        add("sw_addr", 8'h00, 0, 0, o_exec_i);
        add("sw_wr_wait", 8'h00, 0, 0, o_mem_wr);   add("sw_wr_done", 8'h00, 1, 0, o_mem_wr);
        add("jmp_fetch", 8'h9C, 1, 0, o_fetch_go);  add("jmp_decode", 8'h00, 0, 0, o_decode);
        add("jmp_jump", 8'h00, 0, 0, o_jump);
        add("nop_fetch", 8'hC0, 1, 0, o_fetch_go);  add("nop_decode", 8'h00, 0, 0, o_decode);
        add("addi_wait", 8'hA5, 0, 0, o_fetch_wait); add("addi_fetch", 8'hA5, 1, 0, o_fetch_go);
        add("addi_decode", 8'h00, 0, 0, o_decode);  add("addi_exec", 8'h00, 0, 0, o_exec_i);
        add("addi_wb", 8'h00, 0, 0, o_wb_alu);

        // Asynchronous reset before any clock edge.
        reset_n = 1'b1; mem_data = 8'h00; mem_ready = 1'b0; zero = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("reset_async", got, o_reset);

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].md, vecs[i].rdy, vecs[i].z);
            check(vecs[i].name, got, vecs[i].exp);
        end

        // Fetch watchdog expires after 16 cycles without mem_ready.
        do_reset(o_reset);
        for (int i = 1; i <= 16; i++) begin
            drive_cycle(8'h20, 0, 0);
            if (i == 16) check("wd_last_wait", got, o_fetch_wait);
        end
        drive_cycle(8'h20, 1, 0);
        check("wd_fault", got, o_fault);
        drive_cycle(8'h20, 1, 0);
        check("wd_fault_sticky", got, o_fault);

        // mem_ready on the 16th cycle wins over the watchdog.
        do_reset(o_reset);
        for (int i = 1; i <= 15; i++) drive_cycle(8'h20, 0, 0);
        drive_cycle(8'h20, 1, 0);
        check("wd_edge_fetch", got, o_fetch_go);
        drive_cycle(8'h00, 0, 0);
        check("wd_edge_decode", got, o_decode);

        // Reset mid-wait in MEM_RD drops the request with no completing strobe.
        do_reset(o_reset);
        drive_cycle(8'h61, 1, 0);
        drive_cycle(8'h00, 0, 0);
        drive_cycle(8'h00, 0, 0);
        drive_cycle(8'h00, 0, 0);
        check("rst_mid_rd_before", got, o_mem_rd);
        #2 reset_n = 1'b0;
        #1 check("rst_mid_rd_async", got, o_reset);
        drive_cycle(8'h00, 0, 0);
        check("rst_mid_rd_fetch", got, o_fetch_wait);

        // HALT absorbs until reset.
        do_reset(o_reset);
        drive_cycle(8'hF3, 1, 0);
        drive_cycle(8'h00, 0, 0);
        check("halt_decode", got, o_decode);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(8'($urandom), 1'($urandom), 1'($urandom));
            check("halt_hold", got, o_halt);
        end
        #2 reset_n = 1'b0;
        #1 check("halt_reset_clear", halted, 1'b0);

        // Randomized traffic against the instruction-plan model.
        for (int seg = 0; seg < 20; seg++) begin
            int thr;
            thr = (seg % 4 == 3) ? 5 : 60;
            do_reset(o_reset);
            for (int c = 0; c < 150; c++) begin
                logic [7:0] md;
                logic       rdy, z;
                md = 8'($urandom);
                if (md[7:4] == 4'hF && $urandom_range(0, 7) != 0) md[7:4] = 4'($urandom_range(0, 10));
                rdy = ($urandom_range(0, 99) < thr);
                z   = 1'($urandom);
                drive_cycle(md, rdy, z);
                check("random", got, model_out(cur_ph(), m_op, rdy, z));
                model_step(md, rdy);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
